// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM state encodings.
package irq_ctrl_pkg;

    localparam logic [4:0] IRQ_ENABLE  = 5'b11000;
    localparam logic [4:0] IRQ_PENDING = 5'b11001;
    localparam logic [4:0] IRQ_STATUS  = 5'b11010;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_ACTIVE = 2'b10
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index and whether any is set.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         vld
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = 3'd0;
        vld = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? 3'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-detected pending sources, enable mask,
// fixed priority and a request/acknowledge/complete handshake toward the CPU.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               N_SRC    = 4,
    parameter logic [N_SRC-1:0] VEC_MASK = {N_SRC{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             exl,
    output logic             iv,
    output logic [2:0]       irq_id
);

    localparam logic [7:0] VEC_PAD = 8'(VEC_MASK);

    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] enable_r;
    irq_state_e       state_r;
    logic             exl_r;
    logic             iv_r;
    logic [2:0]       irq_id_r;

    logic [N_SRC-1:0] set_s;
    logic [N_SRC-1:0] w1c_s;
    logic [N_SRC-1:0] done_clr_s;
    logic [N_SRC-1:0] pend_nxt_s;
    logic             done_fire_s;
    logic [2:0]       prio_idx_s;
    logic             prio_vld_s;
    logic             unused_ok_s;

    assign unused_ok_s = ^wdata;

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .req (pend_r & enable_r),
        .idx (prio_idx_s),
        .vld (prio_vld_s)
    );

    // Pending next-state: W1C and completion clear, new rising edges always win.
    always_comb begin
        set_s       = src & ~src_q_r;
        done_fire_s = (state_r == S_ACTIVE) && int_done;
        w1c_s       = (we && (addr == IRQ_PENDING)) ? wdata[N_SRC-1:0] : {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            done_clr_s[i] = done_fire_s && (irq_id_r == 3'(i));
        end
        pend_nxt_s = (pend_r & ~w1c_s & ~done_clr_s) | set_s;
    end

    // Source history, pending latch and enable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q_r  <= {N_SRC{1'b0}};
            pend_r   <= {N_SRC{1'b0}};
            enable_r <= {N_SRC{1'b0}};
        end else begin
            src_q_r <= src;
            pend_r  <= pend_nxt_s;
            if (we && (addr == IRQ_ENABLE)) begin
                enable_r <= wdata[N_SRC-1:0];
            end
        end
    end

    // Handshake FSM; the served id and vector are frozen from IDLE->REQ until back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            exl_r    <= 1'b0;
            iv_r     <= 1'b0;
            irq_id_r <= 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (prio_vld_s) begin
                        irq_id_r <= prio_idx_s;
                        iv_r     <= VEC_PAD[prio_idx_s];
                        exl_r    <= 1'b1;
                        state_r  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        exl_r   <= 1'b0;
                        state_r <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (int_done) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    exl_r   <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational register read mux.
    always_comb begin
        case (addr)
            IRQ_ENABLE:  rdata = {{(32 - N_SRC){1'b0}}, enable_r};
            IRQ_PENDING: rdata = {{(32 - N_SRC){1'b0}}, pend_r};
            IRQ_STATUS:  rdata = {27'd0, state_r, irq_id_r};
            default:     rdata = 32'd0;
        endcase
    end

    assign exl    = exl_r;
    assign iv     = iv_r;
    assign irq_id = irq_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table for register/handshake flows plus
// hand-written sequences for latency, held-level, and mid-handshake reset.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_ack;
    logic        int_done;
    logic        exl;
    logic        iv;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_SRC(4), .VEC_MASK(4'b1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .int_ack  (int_ack),
        .int_done (int_done),
        .exl      (exl),
        .iv       (iv),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  src;
        logic        ack;
        logic        done;
        logic        exp_exl;
        logic        exp_iv;
        logic [2:0]  exp_id;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic k, input logic n,
                                input logic e, input logic v, input logic [2:0] id,
                                input logic [31:0] r);
        vec_t t;
        t.we = w; t.addr = a; t.wdata = d; t.src = s; t.ack = k; t.done = n;
        t.exp_exl = e; t.exp_iv = v; t.exp_id = id; t.exp_rdata = r;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we = 1'b0;
        int_ack = 1'b0;
        int_done = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        we = v.we; addr = v.addr; wdata = v.wdata; src = v.src;
        int_ack = v.ack; int_done = v.done;
        step();
        check($sformatf("vec%0d_exl", idx), {31'd0, exl}, {31'd0, v.exp_exl});
        check($sformatf("vec%0d_iv", idx), {31'd0, iv}, {31'd0, v.exp_iv});
        check($sformatf("vec%0d_id", idx), {29'd0, irq_id}, {29'd0, v.exp_id});
        check($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
    endtask

    task automatic read_check(input string nm, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    initial begin
        int n;
        logic seen;
        //           we    addr         wdata  src     ack   done  exl   iv    id    rdata
        vecs[0]  = mk(1'b1, 5'b11011,  32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        vecs[1]  = mk(1'b1, IRQ_ENABLE,  32'h1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h1);
        vecs[2]  = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h1);
        vecs[3]  = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd8);
        vecs[4]  = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd8);
        vecs[5]  = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd16);
        vecs[6]  = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        vecs[7]  = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        vecs[8]  = mk(1'b1, IRQ_ENABLE,  32'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hF);
        vecs[9]  = mk(1'b0, IRQ_PENDING, 32'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hA);
        vecs[10] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'd9);
        vecs[11] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd17);
        vecs[12] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h8);
        vecs[13] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'd11);
        vecs[14] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 32'd19);
        vecs[15] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h0);
        vecs[16] = mk(1'b1, IRQ_ENABLE,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h0);
        vecs[17] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h4);
        vecs[18] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h4);
        vecs[19] = mk(1'b1, IRQ_ENABLE,  32'h4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h4);
        vecs[20] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'd10);
        vecs[21] = mk(1'b0, IRQ_STATUS,  32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'd18);
        vecs[22] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0);
        vecs[23] = mk(1'b1, IRQ_ENABLE,  32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0);
        vecs[24] = mk(1'b1, IRQ_PENDING, 32'h1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h1);
        vecs[25] = mk(1'b1, IRQ_PENDING, 32'h1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0);
        vecs[26] = mk(1'b0, IRQ_PENDING, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0);

        rst = 1'b1; src = 4'b0000; we = 1'b0; addr = IRQ_ENABLE; wdata = 32'd0;
        int_ack = 1'b0; int_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        check("rst_exl", {31'd0, exl}, 32'd0);
        check("rst_iv", {31'd0, iv}, 32'd0);
        check("rst_id", {29'd0, irq_id}, 32'd0);
        read_check("rst_enable", IRQ_ENABLE, 32'd0);
        read_check("rst_pending", IRQ_PENDING, 32'd0);
        read_check("rst_status", IRQ_STATUS, 32'd0);

        for (int i = 0; i < 27; i++) begin
            apply(i, vecs[i]);
        end

        // Source edge to exl latency, then a held level must not retrigger.
        addr = IRQ_ENABLE; wdata = 32'h1; we = 1'b1;
        step();
        src = 4'b0001;
        n = 0;
        while (!exl && n < 10) begin
            step();
            n++;
        end
        check("latency_cycles", 32'(n), 32'd2);
        check("latency_id", {29'd0, irq_id}, 32'd0);
        int_ack = 1'b1;
        step();
        check("ack_drops_exl", {31'd0, exl}, 32'd0);
        int_done = 1'b1;
        step();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (exl) seen = 1'b1;
        end
        check("held_no_retrigger", {31'd0, seen}, 32'd0);
        read_check("held_pending", IRQ_PENDING, 32'd0);
        src = 4'b0000;
        step();

        // Reset asserted while ACTIVE clears everything without a clock edge.
        src = 4'b0001;
        step();
        src = 4'b0000;
        n = 0;
        while (!exl && n < 10) begin
            step();
            n++;
        end
        check("pre_rst_exl", {31'd0, exl}, 32'd1);
        int_ack = 1'b1;
        step();
        read_check("pre_rst_status", IRQ_STATUS, 32'd16);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_exl", {31'd0, exl}, 32'd0);
        read_check("async_rst_status", IRQ_STATUS, 32'd0);
        read_check("async_rst_enable", IRQ_ENABLE, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        int_done = 1'b1;
        step();
        check("spurious_done_exl", {31'd0, exl}, 32'd0);
        read_check("spurious_done_status", IRQ_STATUS, 32'd0);
        read_check("spurious_done_pending", IRQ_PENDING, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the peripheral sources (timer `flag`, debounced push-buttons) and the CPU control decoder's `EXL`/`IV` inputs. It edge-detects up to N request lines, latches them as pending, applies an enable mask and fixed priority, and runs a request/acknowledge/complete handshake with the CPU. It sits on the same 5-bit peripheral address bus as the timer.

## Interface
- `N_SRC`, 4: number of interrupt sources, 1..8.
- `VEC_MASK`, 4'b0000: per-source flag. A 1 drives `iv`=1 while that source is served.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `src` input N_SRC: level request lines, synchronous to `clk`.
- `we` input 1: peripheral write strobe.
- `addr` input 5: peripheral register address.
- `wdata` input 32: write data.
- `rdata` output 32: read data, combinational on `addr`.
- `int_ack` input 1: 1-cycle pulse, CPU has vectored into the handler.
- `int_done` input 1: 1-cycle pulse, handler has returned.
- `exl` output 1: interrupt request to the decoder.
- `iv` output 1: vector select for the served source.
- `irq_id` output 3: index of the served source.

## Operation
- Registers:
  - 5'b11000 ENABLE: read/write, bits [N_SRC-1:0].
  - 5'b11001 PENDING: read; a write clears every bit set in `wdata` (write-1-to-clear).
  - 5'b11010 STATUS: read, {27'b0, state[1:0], irq_id[2:0]}.
  - Any other address: `rdata`=0 and writes are ignored.
- Edge detect: `src_q` holds `src` registered each cycle. `pend[i]` sets on any edge where `src[i]`=1 and `src_q[i]`=0.
- A set and a W1C on the same bit in the same cycle: the set wins.
- Eligible sources = `pend & ENABLE`. The lowest index has highest priority.
- FSM states:
  - IDLE (2'b00): when any source is eligible, latch `irq_id` as the highest-priority eligible index and go to REQ.
  - REQ (2'b01): `exl`=1. On `int_ack`, go to ACTIVE.
  - ACTIVE (2'b10): `exl`=0. On `int_done`, clear `pend[irq_id]` and go to IDLE.
- `int_done` seen in REQ or IDLE is ignored. `int_ack` seen in IDLE or ACTIVE is ignored.
- `irq_id` and `iv` stay stable from IDLE->REQ until the return to IDLE. `iv` = `VEC_MASK[irq_id]`.
- A new edge or a higher-priority edge during REQ/ACTIVE only sets pending. Served requests are never preempted.
- Clearing ENABLE or PENDING for the served source during REQ/ACTIVE does not abort the service.
- Reset values: ENABLE=0, PENDING=0, `src_q`=0, state=IDLE, `exl`=0, `iv`=0, `irq_id`=0. `rdata` follows `addr`.

## Timing
- Request latency: `src` rises before edge k → `pend` set at edge k → state goes REQ and `exl`=1 after edge k+1. That is 2 cycles from source edge to `exl`.
- `exl` falls on the edge that samples `int_ack`.
- Completion: `int_done` sampled at edge m → pend bit cleared and state IDLE at edge m. The earliest next `exl` is after edge m+1, so there is always at least 1 cycle with `exl` low between requests.
- A `src` level held high produces exactly one pending event. It must drop and rise again to retrigger.
- Register writes take effect at the sampling edge. Reads are same-cycle combinational.
- `rst` asserted mid-handshake: all state clears immediately and `exl` drops asynchronously.

## Structure
- Shared package holds:
  - register address constants IRQ_ENABLE=5'b11000, IRQ_PENDING=5'b11001, IRQ_STATUS=5'b11010;
  - state encodings S_IDLE/S_REQ/S_ACTIVE.
- One sub-module: `irq_prio_enc` (combinational N_SRC-input priority encoder producing index + valid).
- The rest is flat: edge detector, pending/enable registers, FSM, read mux.

## Test plan
- Reset, then write ENABLE=4'b0001 and pulse `src[0]` → `exl`=1 two cycles after the edge, `irq_id`=0, `iv`=0. `int_ack` → `exl`=0. `int_done` → PENDING reads 0 and STATUS reads 0.
- ENABLE=4'b1111, `src[3]` and `src[1]` rise in the same cycle, VEC_MASK=4'b1000 → source 1 is served first (`iv`=0). After `int_done`, `exl` re-asserts after one idle cycle with `irq_id`=3 and `iv`=1.
- ENABLE=0, pulse `src[2]` → PENDING=4'b0100 and `exl` stays 0. Write ENABLE=4'b0100 → `exl`=1 next cycle.
- `src[0]` rises in the same cycle as a write of PENDING=1 → `pend[0]` remains 1 (set wins). A later W1C with no edge → `pend[0]`=0.
- `src[0]` held high for 20 cycles after one service → no second `exl`.
- `rst` pulsed while in ACTIVE → `exl`=0, STATUS=0, ENABLE=0 immediately. Spurious `int_done` afterwards → no change.
